// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: tag/data widths, the idle tag value and bus payload types.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_W   = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ENTRY_W = ROB_W + DATA_W;

  // Tag value every reservation station treats as "no broadcast".
  localparam logic [ROB_W-1:0] INVALID_ROB = 6'b010000;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_num;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob_num;
    logic [DATA_W-1:0] data;
  } cdb_chan_t;

  function automatic cdb_chan_t idle_chan();
    cdb_chan_t c;
    c.valid   = 1'b0;
    c.rob_num = INVALID_ROB;
    c.data    = '0;
    return c;
  endfunction

  function automatic cdb_chan_t busy_chan(input cdb_entry_t e);
    cdb_chan_t c;
    c.valid   = 1'b1;
    c.rob_num = e.rob_num;
    c.data    = e.data;
    return c;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-source result FIFO; pointers carry an extra wrap bit to tell full from empty.
module cdb_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 38
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // A full FIFO still accepts a push when its head leaves at the same edge.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers per-unit result pulses and drives the two CDB channels with round-robin
// service; a channel that broadcast last cycle sits idle so consumers see clean edges.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [ROB_W*N_SRC-1:0]  src_rob_num,
  input  logic [DATA_W*N_SRC-1:0] src_data,
  output logic                    CDBiscast,
  output logic [ROB_W-1:0]        CDBrobNum,
  output logic [DATA_W-1:0]       CDBdata,
  output logic                    CDBiscast2,
  output logic [ROB_W-1:0]        CDBrobNum2,
  output logic [DATA_W-1:0]       CDBdata2,
  output logic [N_SRC-1:0]        overflow,
  output logic                    pending
);

  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  cdb_chan_t        r_ch1;
  cdb_chan_t        r_ch2;
  logic [SRC_W-1:0] r_rr;
  logic [N_SRC-1:0] r_overflow;

  cdb_entry_t       w_din  [N_SRC];
  cdb_entry_t       w_head [N_SRC];
  logic [N_SRC-1:0] w_push;
  logic [N_SRC-1:0] w_pop;
  logic [N_SRC-1:0] w_full;
  logic [N_SRC-1:0] w_empty;
  logic [N_SRC-1:0] w_drop;
  logic [SRC_W-1:0] w_scan_idx [N_SRC];

  logic             w_first_vld;
  logic [SRC_W-1:0] w_first_idx;
  logic             w_second_vld;
  logic [SRC_W-1:0] w_second_idx;
  logic             w_gnt1;
  logic [SRC_W-1:0] w_gnt1_idx;
  logic             w_gnt2;
  logic [SRC_W-1:0] w_gnt2_idx;
  logic [SRC_W-1:0] w_rr_nxt;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    assign w_din[k].rob_num = src_rob_num[ROB_W*k +: ROB_W];
    assign w_din[k].data    = src_data[DATA_W*k +: DATA_W];
    assign w_push[k] = src_valid[k] && !flush && (!w_full[k] || w_pop[k]);
    assign w_drop[k] = src_valid[k] && !flush && w_full[k] && !w_pop[k];

    cdb_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (flush),
      .push  (w_push[k]),
      .pop   (w_pop[k]),
      .din   (w_din[k]),
      .dout  (w_head[k]),
      .full  (w_full[k]),
      .empty (w_empty[k])
    );
  end

  // Scan order starts at the round-robin pointer and wraps.
  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      w_scan_idx[i] = SRC_W'((int'(r_rr) + i) % int'(N_SRC));
    end
  end

  // First and second non-empty sources in scan order.
  always_comb begin
    w_first_vld  = 1'b0;
    w_first_idx  = '0;
    w_second_vld = 1'b0;
    w_second_idx = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (!w_empty[w_scan_idx[i]]) begin
        if (!w_first_vld) begin
          w_first_vld = 1'b1;
          w_first_idx = w_scan_idx[i];
        end else if (!w_second_vld) begin
          w_second_vld = 1'b1;
          w_second_idx = w_scan_idx[i];
        end
      end
    end
  end

  // Channel 1 has first pick; a lone eligible channel 2 takes the first source.
  always_comb begin
    w_gnt1     = 1'b0;
    w_gnt1_idx = w_first_idx;
    w_gnt2     = 1'b0;
    w_gnt2_idx = w_second_idx;
    if (!flush) begin
      if (!r_ch1.valid) begin
        w_gnt1 = w_first_vld;
        w_gnt2 = !r_ch2.valid && w_second_vld;
      end else if (!r_ch2.valid) begin
        w_gnt2     = w_first_vld;
        w_gnt2_idx = w_first_idx;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_gnt1) w_pop[w_gnt1_idx] = 1'b1;
    if (w_gnt2) w_pop[w_gnt2_idx] = 1'b1;
  end

  // Channel 2's grant is always the later one in scan order when both fire.
  always_comb begin
    w_rr_nxt = r_rr;
    if (flush)       w_rr_nxt = '0;
    else if (w_gnt2) w_rr_nxt = SRC_W'((int'(w_gnt2_idx) + 1) % int'(N_SRC));
    else if (w_gnt1) w_rr_nxt = SRC_W'((int'(w_gnt1_idx) + 1) % int'(N_SRC));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ch1      <= idle_chan();
      r_ch2      <= idle_chan();
      r_rr       <= '0;
      r_overflow <= '0;
    end else begin
      r_ch1      <= w_gnt1 ? busy_chan(w_head[w_gnt1_idx]) : idle_chan();
      r_ch2      <= w_gnt2 ? busy_chan(w_head[w_gnt2_idx]) : idle_chan();
      r_rr       <= w_rr_nxt;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign CDBiscast  = r_ch1.valid;
  assign CDBrobNum  = r_ch1.rob_num;
  assign CDBdata    = r_ch1.data;
  assign CDBiscast2 = r_ch2.valid;
  assign CDBrobNum2 = r_ch2.rob_num;
  assign CDBdata2   = r_ch2.data;
  assign overflow   = r_overflow;
  assign pending    = |(~w_empty);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-derived per-cycle channel traces per scenario.
module tb_cdb_arbiter;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic [3:0]    src_valid;
  logic [23:0]   src_rob_num;
  logic [127:0]  src_data;
  logic          CDBiscast;
  logic [5:0]    CDBrobNum;
  logic [31:0]   CDBdata;
  logic          CDBiscast2;
  logic [5:0]    CDBrobNum2;
  logic [31:0]   CDBdata2;
  logic [3:0]    overflow;
  logic          pending;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.N_SRC(4), .DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .src_valid   (src_valid),
    .src_rob_num (src_rob_num),
    .src_data    (src_data),
    .CDBiscast   (CDBiscast),
    .CDBrobNum   (CDBrobNum),
    .CDBdata     (CDBdata),
    .CDBiscast2  (CDBiscast2),
    .CDBrobNum2  (CDBrobNum2),
    .CDBdata2    (CDBdata2),
    .overflow    (overflow),
    .pending     (pending)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_src();
    src_valid   = '0;
    src_rob_num = '0;
    src_data    = '0;
  endtask

  task automatic set_src(input int k, input int tag, input logic [31:0] data);
    src_valid[k]          = 1'b1;
    src_rob_num[6*k +: 6] = 6'(tag);
    src_data[32*k +: 32]  = data;
  endtask

  task automatic do_reset();
    clear_src();
    flush = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (CDBiscast !== 1'b0 || CDBrobNum !== 6'd16 || CDBdata !== 32'd0 ||
          CDBiscast2 !== 1'b0 || CDBrobNum2 !== 6'd16 || CDBdata2 !== 32'd0 ||
          pending !== 1'b0 || overflow !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got cast=%b/%b rob=%0d/%0d data=%h/%h pend=%b ovf=%b want 0/0 16/16 0/0 0 0000",
                 i, CDBiscast, CDBiscast2, CDBrobNum, CDBrobNum2, CDBdata, CDBdata2, pending, overflow);
      end
    end
  endtask

  task automatic test_single();
    clear_src();
    set_src(1, 5, 32'h1);
    tick();
    clear_src();
    total++;
    if (CDBiscast !== 1'b0 || CDBiscast2 !== 1'b0 || pending !== 1'b1) begin
      bad++;
      $display("FAIL single_no_bypass got cast=%b/%b pend=%b want 0/0 1", CDBiscast, CDBiscast2, pending);
    end
    tick();
    total++;
    if (CDBiscast !== 1'b1 || CDBrobNum !== 6'd5 || CDBdata !== 32'h1 ||
        CDBiscast2 !== 1'b0 || CDBrobNum2 !== 6'd16 || CDBdata2 !== 32'd0) begin
      bad++;
      $display("FAIL single_bcast got ch1=%b/%0d/%h ch2=%b/%0d/%h want 1/5/1 0/16/0",
               CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2);
    end
    tick();
    total++;
    if (CDBiscast !== 1'b0 || CDBrobNum !== 6'd16 || CDBdata !== 32'd0 || pending !== 1'b0) begin
      bad++;
      $display("FAIL single_after got cast=%b rob=%0d data=%h pend=%b want 0 16 0 0",
               CDBiscast, CDBrobNum, CDBdata, pending);
    end
  endtask

  task automatic test_back_to_back();
    int ev1 [6] = '{0, 1, 0, 1, 0, 0};
    int er1 [6] = '{16, 1, 16, 3, 16, 16};
    int ev2 [6] = '{0, 0, 1, 0, 1, 0};
    int er2 [6] = '{16, 16, 2, 16, 4, 16};
    logic [31:0] ed1, ed2;
    do_reset();
    for (int e = 0; e < 6; e++) begin
      clear_src();
      if (e < 4) set_src(0, e + 1, 32'(e + 1) + 32'h100);
      tick();
      ed1 = (ev1[e] != 0) ? 32'(er1[e]) + 32'h100 : 32'd0;
      ed2 = (ev2[e] != 0) ? 32'(er2[e]) + 32'h100 : 32'd0;
      total++;
      if (CDBiscast !== 1'(ev1[e]) || CDBrobNum !== 6'(er1[e]) || CDBdata !== ed1 ||
          CDBiscast2 !== 1'(ev2[e]) || CDBrobNum2 !== 6'(er2[e]) || CDBdata2 !== ed2) begin
        bad++;
        $display("FAIL burst e=%0d got ch1=%b/%0d/%h ch2=%b/%0d/%h want %0d/%0d/%h %0d/%0d/%h",
                 e, CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2,
                 ev1[e], er1[e], ed1, ev2[e], er2[e], ed2);
      end
    end
    total++;
    if (pending !== 1'b0) begin
      bad++;
      $display("FAIL burst_drain got pend=%b want 0", pending);
    end
  endtask

  task automatic test_round_robin();
    int ev1 [5] = '{0, 1, 0, 1, 0};
    int er1 [5] = '{16, 10, 16, 12, 16};
    int ev2 [5] = '{0, 1, 0, 1, 0};
    int er2 [5] = '{16, 11, 16, 13, 16};
    logic [31:0] ed1, ed2;
    do_reset();
    for (int e = 0; e < 5; e++) begin
      clear_src();
      if (e == 0) for (int k = 0; k < 4; k++) set_src(k, 10 + k, 32'(10 + k) + 32'h100);
      tick();
      ed1 = (ev1[e] != 0) ? 32'(er1[e]) + 32'h100 : 32'd0;
      ed2 = (ev2[e] != 0) ? 32'(er2[e]) + 32'h100 : 32'd0;
      total++;
      if (CDBiscast !== 1'(ev1[e]) || CDBrobNum !== 6'(er1[e]) || CDBdata !== ed1 ||
          CDBiscast2 !== 1'(ev2[e]) || CDBrobNum2 !== 6'(er2[e]) || CDBdata2 !== ed2) begin
        bad++;
        $display("FAIL rr e=%0d got ch1=%b/%0d/%h ch2=%b/%0d/%h want %0d/%0d/%h %0d/%0d/%h",
                 e, CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2,
                 ev1[e], er1[e], ed1, ev2[e], er2[e], ed2);
      end
    end
    total++;
    if (pending !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain got pend=%b want 0", pending);
    end
  endtask

  // Sources 0/1/3 push at edges 0-1, source 2 pushes tags 40..45 at edges 0-5.
  task automatic test_overflow();
    int ev1 [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int er1 [13] = '{16, 20, 16, 40, 16, 21, 16, 41, 16, 42, 16, 44, 16};
    int ev2 [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0};
    int er2 [13] = '{16, 30, 16, 50, 16, 31, 16, 51, 16, 16, 43, 16, 16};
    logic [31:0] ed1;
    do_reset();
    for (int e = 0; e < 13; e++) begin
      clear_src();
      if (e <= 1) begin
        set_src(0, 20 + e, 32'(20 + e) + 32'h100);
        set_src(1, 30 + e, 32'(30 + e) + 32'h100);
        set_src(3, 50 + e, 32'(50 + e) + 32'h100);
      end
      if (e <= 5) set_src(2, 40 + e, 32'(40 + e) + 32'h100);
      tick();
      ed1 = (ev1[e] != 0) ? 32'(er1[e]) + 32'h100 : 32'd0;
      total++;
      if (CDBiscast !== 1'(ev1[e]) || CDBrobNum !== 6'(er1[e]) || CDBdata !== ed1 ||
          CDBiscast2 !== 1'(ev2[e]) || CDBrobNum2 !== 6'(er2[e])) begin
        bad++;
        $display("FAIL ovf_trace e=%0d got ch1=%b/%0d/%h ch2=%b/%0d want %0d/%0d/%h %0d/%0d",
                 e, CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2,
                 ev1[e], er1[e], ed1, ev2[e], er2[e]);
      end
      if (e == 4) begin
        total++;
        if (overflow !== 4'b0000) begin
          bad++;
          $display("FAIL ovf_early got ovf=%b want 0000", overflow);
        end
      end
      if (e == 5) begin
        total++;
        if (overflow !== 4'b0100) begin
          bad++;
          $display("FAIL ovf_set got ovf=%b want 0100", overflow);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (CDBiscast !== 1'b0 || CDBiscast2 !== 1'b0 || pending !== 1'b0 || overflow !== 4'b0100) begin
        bad++;
        $display("FAIL ovf_tail i=%0d got cast=%b/%b rob=%0d/%0d pend=%b ovf=%b want 0/0 0 0100",
                 i, CDBiscast, CDBiscast2, CDBrobNum, CDBrobNum2, pending, overflow);
      end
    end
  endtask

  // Runs without reset so the sticky overflow flag and a non-zero rr are carried in.
  task automatic test_flush();
    clear_src();
    set_src(0, 1, 32'h101);
    set_src(1, 2, 32'h102);
    set_src(2, 3, 32'h103);
    tick();
    total++;
    if (pending !== 1'b1 || CDBiscast !== 1'b0) begin
      bad++;
      $display("FAIL flush_setup got pend=%b cast=%b want 1 0", pending, CDBiscast);
    end
    clear_src();
    set_src(3, 9, 32'h109);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_src();
    total++;
    if (CDBiscast !== 1'b0 || CDBiscast2 !== 1'b0 || CDBrobNum !== 6'd16 || CDBrobNum2 !== 6'd16 ||
        pending !== 1'b0 || overflow !== 4'b0100) begin
      bad++;
      $display("FAIL flush_edge got cast=%b/%b rob=%0d/%0d pend=%b ovf=%b want 0/0 16/16 0 0100",
               CDBiscast, CDBiscast2, CDBrobNum, CDBrobNum2, pending, overflow);
    end
    tick();
    total++;
    if (CDBiscast !== 1'b0 || CDBiscast2 !== 1'b0 || pending !== 1'b0) begin
      bad++;
      $display("FAIL flush_quiet got cast=%b/%b pend=%b want 0/0 0", CDBiscast, CDBiscast2, pending);
    end
    set_src(0, 8, 32'h108);
    set_src(3, 7, 32'h107);
    tick();
    clear_src();
    tick();
    total++;
    if (CDBiscast !== 1'b1 || CDBrobNum !== 6'd8 || CDBdata !== 32'h108 ||
        CDBiscast2 !== 1'b1 || CDBrobNum2 !== 6'd7 || CDBdata2 !== 32'h107) begin
      bad++;
      $display("FAIL flush_resume got ch1=%b/%0d/%h ch2=%b/%0d/%h want 1/8/108 1/7/107",
               CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2);
    end
    tick();
    total++;
    if (CDBiscast !== 1'b0 || CDBiscast2 !== 1'b0 || pending !== 1'b0) begin
      bad++;
      $display("FAIL flush_end got cast=%b/%b pend=%b want 0/0 0", CDBiscast, CDBiscast2, pending);
    end
  endtask

  task automatic test_reset_midburst();
    clear_src();
    set_src(0, 60, 32'h160);
    set_src(1, 61, 32'h161);
    set_src(2, 62, 32'h162);
    tick();
    clear_src();
    set_src(0, 63, 32'h163);
    tick();
    total++;
    if (CDBiscast !== 1'b1 || CDBrobNum !== 6'd60 || CDBiscast2 !== 1'b1 || CDBrobNum2 !== 6'd61 ||
        pending !== 1'b1) begin
      bad++;
      $display("FAIL midburst_pre got ch1=%b/%0d ch2=%b/%0d pend=%b want 1/60 1/61 1",
               CDBiscast, CDBrobNum, CDBiscast2, CDBrobNum2, pending);
    end
    clear_src();
    set_src(1, 64, 32'h164);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_src();
    total++;
    if (CDBiscast !== 1'b0 || CDBrobNum !== 6'd16 || CDBdata !== 32'd0 || CDBiscast2 !== 1'b0 ||
        CDBrobNum2 !== 6'd16 || CDBdata2 !== 32'd0 || pending !== 1'b0 || overflow !== 4'b0000) begin
      bad++;
      $display("FAIL midburst_reset got cast=%b/%b rob=%0d/%0d data=%h/%h pend=%b ovf=%b want idle 0 0000",
               CDBiscast, CDBiscast2, CDBrobNum, CDBrobNum2, CDBdata, CDBdata2, pending, overflow);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (CDBiscast !== 1'b0 || CDBiscast2 !== 1'b0 || pending !== 1'b0) begin
        bad++;
        $display("FAIL midburst_after i=%0d got cast=%b/%b pend=%b want 0/0 0",
                 i, CDBiscast, CDBiscast2, pending);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_src();
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_overflow();
    test_flush();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-collection and Common Data Bus (CDB) driver for the Tomasulo core, downstream of the functional-unit reservation stations (add, bne, load, etc.). Each station emits a one-cycle result pulse with no backpressure. This block buffers those results per source and broadcasts them over the two CDB channels (`CDBiscast`/`CDBrobNum`/`CDBdata` and the `...2` set) consumed by every reservation station and the ROB. It guarantees edge-detectable pulses, fair round-robin service, and no silent loss except on declared overflow.

## Interface
- `N_SRC`, 4: number of result sources (2..8)
- `DEPTH`, 4: entries per source FIFO (power of two)
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `flush`  in  1  synchronous; discards all buffered results (branch mispredict)
- `src_valid`  in  N_SRC  bit k: source k result pulse this cycle
- `src_rob_num`  in  6*N_SRC  slice [6k+5:6k]: destination ROB tag of source k
- `src_data`  in  32*N_SRC  slice [32k+31:32k]: result value of source k
- `CDBiscast`, `CDBiscast2`  out  1  channel 1/2 broadcast pulse
- `CDBrobNum`, `CDBrobNum2`  out  6  channel tag; `6'b010000` when idle
- `CDBdata`, `CDBdata2`  out  32  channel value; 0 when idle
- `overflow`  out  N_SRC  sticky per-source drop flag
- `pending`  out  1  any FIFO non-empty

## Operation
- Enqueue: at each edge, every source with `src_valid`=1 pushes {rob_num, data} into its FIFO. If the FIFO is full and not popped at the same edge, the entry is dropped and `overflow[k]` is set. The flag stays set until reset.
- Push and pop on the same FIFO at the same edge are both honoured. A full FIFO with a simultaneous pop accepts the push.
- Consumers are edge-sensitive. A channel that broadcast in cycle c is idle in cycle c+1: `CDBiscast*` is low and the outputs hold idle values. Each channel therefore broadcasts at most every other cycle.
- Eligible channel: one not broadcasting this cycle.
- Arbitration at each edge uses round-robin pointer `rr` (0..N_SRC-1):
  - Scan sources rr, rr+1, … (mod N_SRC).
  - If channel 1 is eligible, it takes the head of the first non-empty FIFO.
  - If channel 2 is eligible, it takes the head of the next non-empty FIFO from a different source.
  - If only channel 2 is eligible, it takes the first non-empty FIFO.
  - At most one pop per source per edge. Per-source order is strict FIFO.
- `rr` advances to (last granted source + 1) mod N_SRC. If nothing is granted, `rr` holds.
- A given ROB tag never appears on both channels in the same cycle; granted entries are distinct.
- `flush`=1 at an edge:
  - empties all FIFOs and drops that cycle's `src_valid` pushes;
  - forces both channels idle for the next cycle;
  - resets `rr` to 0;
  - leaves `overflow` unchanged.
- `pending` = OR of FIFO non-empty flags (combinational from state).

## Timing
- Reset values:
  - all `CDBiscast*` 0;
  - `CDBrobNum*` = `6'b010000`;
  - `CDBdata*` = 0;
  - `overflow` = 0; `pending` = 0; `rr` = 0.
  - FIFOs empty, both channels eligible.
- Reset takes priority over `flush` and pushes. A reset asserted mid-burst drops all buffered results; the outputs are idle after that edge.
- Latency:
  - `src_valid` sampled at edge E is enqueued at E.
  - The earliest broadcast is registered at E+1, valid from E+1 to E+2. There is no bypass.
- All outputs are registered. Idle values are driven whenever `CDBiscast*` is 0.
- Throughput: 1 result per cycle sustained. The two channels alternate when load is continuous.

## Structure
- Shared package/include holds `ROB_W`=6, `DATA_W`=32, `INVALID_ROB`=`6'b010000`. The same constant is used by all reservation stations.
- Sub-module `cdb_result_fifo` (parameter `DEPTH`, width 38) is instantiated N_SRC times. Ports: push, pop, din, dout, full, empty, using a wrap-around pointer with an extra bit.
- Top-level holds the arbiter, `rr`, per-channel recovery flags, and output registers.

## Test plan
- Reset then idle: after reset, `CDBiscast`=0, `CDBrobNum`=16, `pending`=0 for 10 cycles.
- Single result: source 1 pulses tag 5, data 0x1 at E. Response: `CDBiscast`=1, `CDBrobNum`=5, `CDBdata`=1 during E+1 only; channel 2 idle.
- Burst from one source: source 0 pushes tags 1,2,3,4 on consecutive edges. Response: broadcasts in order 1,2,3,4, alternating ch1/ch2, and every `CDBiscast*` pulse is followed by a low cycle.
- Round-robin fairness: all 4 sources pulse simultaneously with tags 10..13. Response: (10 on ch1, 11 on ch2), then (12 on ch1 or ch2 per eligibility), then 13; no tag repeated or lost.
- Overflow: source 2 pushes 6 results while channels are blocked by sources 0/1 traffic. Response: `overflow[2]`=1, exactly DEPTH+pops entries broadcast, and the remainder are never broadcast.
- Flush mid-burst: with 3 entries buffered, assert `flush` together with a new `src_valid`. Response: no broadcast next cycle, `pending`=0, `overflow` unchanged; a later push of tag 7 broadcasts normally.
